// File: rtl/gpio_bank.sv
// Memory-mapped GPIO bank: NUM_PORTS ports of PIN_WIDTH pins, each with direction, output latch,
// synchronised input, atomic set/clear and rise/fall edge capture feeding one level interrupt.
module gpio_bank #(
    parameter logic [31:0] BASE_ADDR = 32'd256,
    parameter int          NUM_PORTS = 4,
    parameter int          PIN_WIDTH = 16
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [31:0]                    address,
    input  logic [63:0]                    wdata,
    input  logic                           write_en,
    input  logic                           read_en,
    output logic                           sel,
    output logic [63:0]                    rdata,
    output logic                           rdata_valid,
    input  logic [NUM_PORTS*PIN_WIDTH-1:0] gpio_in,
    output logic [NUM_PORTS*PIN_WIDTH-1:0] gpio_out,
    output logic [NUM_PORTS*PIN_WIDTH-1:0] gpio_oe,
    output logic                           irq
);

    localparam logic [31:0] SPAN     = 32'(8 * NUM_PORTS);
    localparam logic [2:0]  OFF_DIR  = 3'd0;
    localparam logic [2:0]  OFF_OUT  = 3'd1;
    localparam logic [2:0]  OFF_IN   = 3'd2;
    localparam logic [2:0]  OFF_SET  = 3'd3;
    localparam logic [2:0]  OFF_CLR  = 3'd4;
    localparam logic [2:0]  OFF_RISE = 3'd5;
    localparam logic [2:0]  OFF_FALL = 3'd6;
    localparam logic [2:0]  OFF_STAT = 3'd7;

    function automatic logic [PIN_WIDTH-1:0] read_mux(
        input logic [2:0]           off,
        input logic [PIN_WIDTH-1:0] dir,
        input logic [PIN_WIDTH-1:0] out,
        input logic [PIN_WIDTH-1:0] pin,
        input logic [PIN_WIDTH-1:0] ren,
        input logic [PIN_WIDTH-1:0] fen,
        input logic [PIN_WIDTH-1:0] stat
    );
        case (off)
            OFF_DIR:  read_mux = dir;
            OFF_OUT:  read_mux = out;
            OFF_IN:   read_mux = pin;
            OFF_RISE: read_mux = ren;
            OFF_FALL: read_mux = fen;
            OFF_STAT: read_mux = stat;
            default:  read_mux = '0;
        endcase
    endfunction

    logic [31:0]                            w_rel;
    logic [28:0]                            w_idx;
    logic [2:0]                             w_off;
    logic                                   w_sel;
    logic [NUM_PORTS-1:0]                   w_hit;
    logic [NUM_PORTS-1:0]                   w_stat_any;
    logic [NUM_PORTS-1:0][PIN_WIDTH-1:0]    w_port_rd;
    logic [PIN_WIDTH-1:0]                   w_rd_word;
    logic [PIN_WIDTH-1:0]                   w_wd;
    logic                                   w_unused;

    // BASE_ADDR is 8-aligned, so the low offset bits of the relative address equal address[2:0]
    assign w_rel    = address - BASE_ADDR;
    assign w_idx    = w_rel[31:3];
    assign w_off    = w_rel[2:0];
    assign w_sel    = (address >= BASE_ADDR) && (w_rel < SPAN);
    assign sel      = w_sel;
    assign w_wd     = wdata[PIN_WIDTH-1:0];
    assign w_unused = ^wdata;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        logic [PIN_WIDTH-1:0] r_dir, r_out, r_s1, r_s2, r_prev, r_rise_en, r_fall_en, r_stat;
        logic [PIN_WIDTH-1:0] w_rise, w_fall, w_w1c;
        logic                 w_wr;

        assign w_hit[g] = w_sel && (w_idx == 29'(g));
        assign w_wr     = write_en && w_hit[g];
        assign w_rise   = r_s2 & ~r_prev & r_rise_en;
        assign w_fall   = ~r_s2 & r_prev & r_fall_en;
        assign w_w1c    = (w_wr && (w_off == OFF_STAT)) ? w_wd : '0;

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                r_dir     <= '0;
                r_out     <= '0;
                r_s1      <= '0;
                r_s2      <= '0;
                r_prev    <= '0;
                r_rise_en <= '0;
                r_fall_en <= '0;
                r_stat    <= '0;
            end else begin
                r_s1   <= gpio_in[g*PIN_WIDTH +: PIN_WIDTH];
                r_s2   <= r_s1;
                r_prev <= r_s2;
                // OR-ing new edges after the clear makes a same-cycle edge win over W1C
                r_stat <= (r_stat & ~w_w1c) | w_rise | w_fall;
                if (w_wr) begin
                    case (w_off)
                        OFF_DIR:  r_dir     <= w_wd;
                        OFF_OUT:  r_out     <= w_wd;
                        OFF_SET:  r_out     <= r_out | w_wd;
                        OFF_CLR:  r_out     <= r_out & ~w_wd;
                        OFF_RISE: r_rise_en <= w_wd;
                        OFF_FALL: r_fall_en <= w_wd;
                        default:  ;
                    endcase
                end
            end
        end

        assign w_port_rd[g]  = w_hit[g] ? read_mux(w_off, r_dir, r_out, r_s2, r_rise_en, r_fall_en, r_stat)
                                        : '0;
        assign w_stat_any[g] = |r_stat;
        assign gpio_out[g*PIN_WIDTH +: PIN_WIDTH] = r_out;
        assign gpio_oe[g*PIN_WIDTH +: PIN_WIDTH]  = r_dir;
    end

    always_comb begin
        w_rd_word = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_rd_word = w_rd_word | w_port_rd[p];
        end
    end

    logic [63:0] r_rdata;
    logic        r_rdata_valid;
    logic        r_irq;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
            r_irq         <= 1'b0;
        end else begin
            r_rdata       <= (read_en && w_sel) ? 64'(w_rd_word) : '0;
            r_rdata_valid <= read_en && w_sel;
            r_irq         <= |w_stat_any;
        end
    end

    assign rdata       = r_rdata;
    assign rdata_valid = r_rdata_valid;
    assign irq         = r_irq;

endmodule

// File: tb/tb_gpio_bank.sv
// Bench for gpio_bank: directed scenarios plus randomized accesses and pin activity,
// every cycle compared against an array-based reference model of the register map.
module tb_gpio_bank;

    localparam logic [31:0] BASE = 32'd256;
    localparam int          NP   = 4;
    localparam int          PW   = 16;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [31:0]       address = '0;
    logic [63:0]       wdata = '0;
    logic              write_en = 1'b0;
    logic              read_en = 1'b0;
    logic              sel;
    logic [63:0]       rdata;
    logic              rdata_valid;
    logic [NP*PW-1:0]  gpio_in = '0;
    logic [NP*PW-1:0]  gpio_out;
    logic [NP*PW-1:0]  gpio_oe;
    logic              irq;

    gpio_bank #(.BASE_ADDR(BASE), .NUM_PORTS(NP), .PIN_WIDTH(PW)) dut (
        .clock(clock), .reset(reset), .address(address), .wdata(wdata),
        .write_en(write_en), .read_en(read_en), .sel(sel), .rdata(rdata),
        .rdata_valid(rdata_valid), .gpio_in(gpio_in), .gpio_out(gpio_out),
        .gpio_oe(gpio_oe), .irq(irq)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: register map as arrays, pad history as a 3-deep delay line
    logic [PW-1:0] m_dir [NP];
    logic [PW-1:0] m_out [NP];
    logic [PW-1:0] m_ren [NP];
    logic [PW-1:0] m_fen [NP];
    logic [PW-1:0] m_stat[NP];
    logic [PW-1:0] h1[NP], h2[NP], h3[NP];
    logic [63:0]   m_rdata;
    logic          m_rv;
    logic          m_irq;

    function automatic logic model_sel(input logic [31:0] a);
        return (a >= BASE) && ((a - BASE) < 32'(8 * NP));
    endfunction

    task automatic model_reset();
        for (int q = 0; q < NP; q++) begin
            m_dir[q] = '0; m_out[q] = '0; m_ren[q] = '0; m_fen[q] = '0; m_stat[q] = '0;
            h1[q] = '0; h2[q] = '0; h3[q] = '0;
        end
        m_rdata = '0; m_rv = 1'b0; m_irq = 1'b0;
    endtask

    task automatic model_edge();
        logic [PW-1:0] mask, wd;
        logic [63:0]   rd;
        logic          s, any;
        int            p, off;
        if (!reset) return;
        s = model_sel(address);
        p = 0; off = 0;
        if (s) begin
            p   = int'((address - BASE) / 8);
            off = int'(address % 8);
        end
        wd  = wdata[PW-1:0];
        any = 1'b0;
        for (int q = 0; q < NP; q++) any = any | (m_stat[q] != '0);
        rd = '0;
        if (s && read_en) begin
            case (off)
                0: rd = 64'(m_dir[p]);
                1: rd = 64'(m_out[p]);
                2: rd = 64'(h2[p]);
                5: rd = 64'(m_ren[p]);
                6: rd = 64'(m_fen[p]);
                7: rd = 64'(m_stat[p]);
                default: rd = '0;
            endcase
        end
        m_rdata = rd;
        m_rv    = s && read_en;
        m_irq   = any;
        for (int q = 0; q < NP; q++) begin
            mask = (s && write_en && off == 7 && p == q) ? wd : '0;
            m_stat[q] = (m_stat[q] & ~mask) | (h2[q] & ~h3[q] & m_ren[q]) | (~h2[q] & h3[q] & m_fen[q]);
        end
        if (s && write_en) begin
            case (off)
                0: m_dir[p] = wd;
                1: m_out[p] = wd;
                3: m_out[p] = m_out[p] | wd;
                4: m_out[p] = m_out[p] & ~wd;
                5: m_ren[p] = wd;
                6: m_fen[p] = wd;
                default: ;
            endcase
        end
        for (int q = 0; q < NP; q++) begin
            h3[q] = h2[q];
            h2[q] = h1[q];
            h1[q] = gpio_in[q*PW +: PW];
        end
    endtask

    task automatic compare_all();
        logic [NP*PW-1:0] eo, ee;
        for (int q = 0; q < NP; q++) begin
            eo[q*PW +: PW] = m_out[q];
            ee[q*PW +: PW] = m_dir[q];
        end
        check("gpio_out", 64'(gpio_out), 64'(eo));
        check("gpio_oe", 64'(gpio_oe), 64'(ee));
        check("irq", 64'(irq), 64'(m_irq));
        check("rdata", rdata, m_rdata);
        check("rdata_valid", 64'(rdata_valid), 64'(m_rv));
    endtask

    // One bus cycle: drive away from the edge, check sel, clock, then check registered outputs
    task automatic cyc(input logic [31:0] a, input logic [63:0] d, input logic we, input logic re);
        address = a; wdata = d; write_en = we; read_en = re;
        #1;
        check("sel", 64'(sel), 64'(model_sel(a)));
        @(posedge clock);
        model_edge();
        #1;
        compare_all();
        write_en = 1'b0; read_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(32'd0, 64'd0, 1'b0, 1'b0);
    endtask

    task automatic mid_reset();
        address = BASE + 32'd1; read_en = 1'b1; write_en = 1'b0;
        reset = 1'b0;
        model_reset();
        #1;
        compare_all();
        check("rst_oe", 64'(gpio_oe), 64'd0);
        check("rst_out", 64'(gpio_out), 64'd0);
        @(posedge clock);
        #1;
        compare_all();
        check("rst_rv", 64'(rdata_valid), 64'd0);
        reset = 1'b1; read_en = 1'b0;
        cyc(BASE + 32'd0, 64'd0, 1'b0, 1'b1);
        check("rst_rd_dir", rdata, 64'd0);
        cyc(BASE + 32'd1, 64'd0, 1'b0, 1'b1);
        check("rst_rd_out", rdata, 64'd0);
    endtask

    initial begin
        logic [31:0] a;
        int          r;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        compare_all();
        reset = 1'b1;

        cyc(BASE + 32'd16, 64'h00FF, 1'b1, 1'b0);
        cyc(BASE + 32'd17, 64'h1234, 1'b1, 1'b0);
        check("p2_oe", 64'(gpio_oe[47:32]), 64'h00FF);
        check("p2_out", 64'(gpio_out[47:32]), 64'h1234);
        cyc(BASE + 32'd19, 64'h8000, 1'b1, 1'b0);
        check("p2_set", 64'(gpio_out[47:32]), 64'h9234);
        cyc(BASE + 32'd20, 64'h0004, 1'b1, 1'b0);
        check("p2_clr", 64'(gpio_out[47:32]), 64'h9230);

        gpio_in[15:0] = 16'hA5A5;
        idle(2);
        cyc(BASE + 32'd2, 64'd0, 1'b0, 1'b1);
        check("in_rd", rdata, 64'hA5A5);
        check("in_rv", 64'(rdata_valid), 64'd1);
        cyc(BASE + 32'd3, 64'd0, 1'b0, 1'b1);
        check("set_rd", rdata, 64'd0);

        gpio_in[17:16] = 2'b10;
        idle(4);
        cyc(BASE + 32'd13, 64'h0001, 1'b1, 1'b0);
        cyc(BASE + 32'd14, 64'h0002, 1'b1, 1'b0);
        gpio_in[17:16] = 2'b01;
        idle(4);
        check("edge_irq", 64'(irq), 64'd1);
        cyc(BASE + 32'd15, 64'd0, 1'b0, 1'b1);
        check("edge_stat", rdata, 64'h3);
        cyc(BASE + 32'd15, 64'h1, 1'b1, 1'b0);
        cyc(BASE + 32'd15, 64'd0, 1'b0, 1'b1);
        check("w1c_stat", rdata, 64'h2);
        cyc(BASE + 32'd15, 64'h2, 1'b1, 1'b0);
        check("w1c_irq_hold", 64'(irq), 64'd1);
        idle(1);
        check("w1c_irq_drop", 64'(irq), 64'd0);

        gpio_in[16] = 1'b0;
        idle(4);
        gpio_in[16] = 1'b1;
        idle(4);
        gpio_in[16] = 1'b0;
        idle(4);
        gpio_in[16] = 1'b1;
        idle(2);
        cyc(BASE + 32'd15, 64'h1, 1'b1, 1'b0);
        check("coll_irq", 64'(irq), 64'd1);
        cyc(BASE + 32'd15, 64'd0, 1'b0, 1'b1);
        check("coll_stat", rdata, 64'h1);

        cyc(BASE - 32'd1, 64'hFFFF, 1'b1, 1'b1);
        check("dec_lo_rv", 64'(rdata_valid), 64'd0);
        cyc(BASE + 32'(8 * NP), 64'hFFFF, 1'b1, 1'b1);
        check("dec_hi_rv", 64'(rdata_valid), 64'd0);
        check("dec_oe", 64'(gpio_oe[15:0]), 64'd0);

        for (int i = 0; i < 2000; i++) begin
            if (i == 1000) mid_reset();
            r = int'($urandom_range(0, 15));
            if (r == 0)      a = BASE - 32'($urandom_range(1, 8));
            else if (r == 1) a = BASE + 32'(8 * NP) + 32'($urandom_range(0, 8));
            else             a = BASE + 32'($urandom_range(0, 8 * NP - 1));
            if ($urandom_range(0, 3) == 0)
                gpio_in = gpio_in ^ ({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
            cyc(a, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
